// File: rtl/isa_pkg.sv
// isa_pkg: instruction-set constants shared by the control decoder and the
// instruction encoder/loader.
//   - op codes for the three legal instruction classes
//   - bit positions/widths of every instruction field
//   - loader_state_t, the state type of the loader FSM
package isa_pkg;

  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_B   = 2'b10;

  // Field placement inside a 32-bit machine word.
  localparam int unsigned COND_LSB   = 28;
  localparam int unsigned COND_W     = 4;
  localparam int unsigned OP_LSB     = 26;
  localparam int unsigned OP_W       = 2;
  localparam int unsigned FUNCT_LSB  = 20;
  localparam int unsigned FUNCT_W    = 6;
  localparam int unsigned RN_LSB     = 16;
  localparam int unsigned RD_LSB     = 12;
  localparam int unsigned REG_W      = 4;
  localparam int unsigned SRC2_LSB   = 0;
  localparam int unsigned SRC2_W     = 12;
  // Branches keep only funct[5:4] directly above imm24.
  localparam int unsigned BFUNCT_LSB = 24;
  localparam int unsigned BFUNCT_W   = 2;
  localparam int unsigned IMM24_LSB  = 0;
  localparam int unsigned IMM24_W    = 24;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    FULL,
    DONE
  } loader_state_t;

endpackage

// File: rtl/instr_encoder_loader_if.sv
// instr_encoder_loader_if: field-bundle handshake from the host plus the
// instruction-memory write port driven by the loader.
//   master : host / memory side (drives the bundle, observes in_ready and imem_*)
//   slave  : loader side (accepts the bundle, drives in_ready and imem_*)
interface instr_encoder_loader_if #(
  parameter int unsigned ADDR_W = 6
) ();

  // Field bundle handshake
  logic              in_valid;
  logic              in_ready;
  logic              in_last;
  logic [3:0]        cond;
  logic [1:0]        op;
  logic [5:0]        funct;
  logic [3:0]        rn;
  logic [3:0]        rd;
  logic [23:0]       operand;

  // imem write port
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;

  modport master (
    output in_valid, in_last, cond, op, funct, rn, rd, operand,
    input  in_ready, imem_we, imem_addr, imem_wdata
  );

  modport slave (
    input  in_valid, in_last, cond, op, funct, rn, rd, operand,
    output in_ready, imem_we, imem_addr, imem_wdata
  );

endinterface

// File: rtl/instr_packer.sv
// instr_packer: purely combinational field-to-word encoder.
//   cond_i, op_i, funct_i, rn_i, rd_i, operand_i : instruction fields
//   word_o    : packed 32-bit machine word
//   illegal_o : op_i is not a legal class; word_o must not be written
// DP/MEM : {cond, op, funct, rn, rd, operand[11:0]}
// B      : {cond, 2'b10, funct[5:4], operand[23:0]}
module instr_packer
  import isa_pkg::*;
(
  input  logic [3:0]  cond_i,
  input  logic [1:0]  op_i,
  input  logic [5:0]  funct_i,
  input  logic [3:0]  rn_i,
  input  logic [3:0]  rd_i,
  input  logic [23:0] operand_i,
  output logic [31:0] word_o,
  output logic        illegal_o
);

  always_comb begin
    word_o    = '0;
    illegal_o = 1'b0;
    word_o[COND_LSB +: COND_W] = cond_i;
    word_o[OP_LSB +: OP_W]     = op_i;
    case (op_i)
      OP_DP, OP_MEM: begin
        // operand[23:12] has no slot in DP/MEM words and is dropped.
        word_o[FUNCT_LSB +: FUNCT_W] = funct_i;
        word_o[RN_LSB +: REG_W]      = rn_i;
        word_o[RD_LSB +: REG_W]      = rd_i;
        word_o[SRC2_LSB +: SRC2_W]   = operand_i[SRC2_W-1:0];
      end
      OP_B: begin
        // Only the link/flag bits survive; rn/rd are not encoded.
        word_o[BFUNCT_LSB +: BFUNCT_W] = funct_i[5:4];
        word_o[IMM24_LSB +: IMM24_W]   = operand_i[IMM24_W-1:0];
      end
      default: begin
        illegal_o = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/instr_encoder_loader.sv
// instr_encoder_loader: encodes field bundles into machine words and streams
// them into instruction memory, holding the core in reset while loading.
//   clk, reset  : clock, synchronous active-high reset
//   start       : one-cycle pulse opening a load session (ignored while busy)
//   bus         : slave side of the bundle handshake and imem write port
//   core_hold   : keeps the core in reset until a session completes
//   busy        : session in progress (LOAD, FULL, DONE)
//   done        : one-cycle pulse at session end
//   err         : sticky; illegal op or discarded bundle, cleared by start
//   word_count  : words written in the current or last session
module instr_encoder_loader
  import isa_pkg::*;
#(
  parameter int unsigned ADDR_W    = 6,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  instr_encoder_loader_if.slave  bus,
  output logic                   core_hold,
  output logic                   busy,
  output logic                   done,
  output logic                   err,
  output logic [ADDR_W:0]        word_count
);

  localparam logic [ADDR_W-1:0] BaseAddr = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] LastAddr = '1;
  localparam logic [ADDR_W-1:0] AddrOne  = ADDR_W'(1);
  localparam logic [ADDR_W:0]   CountOne = (ADDR_W + 1)'(1);

  loader_state_t     state_q, state_d;
  logic              last_q, last_d;       // legal in_last word written, DONE next
  logic [ADDR_W-1:0] addr_q, addr_d;       // next address to write
  logic              we_q, we_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              core_hold_q, core_hold_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic [ADDR_W:0]   count_q, count_d;

  logic [31:0]       pk_word;
  logic              pk_illegal;
  logic              in_ready;
  logic              accept;

  instr_packer u_packer (
    .cond_i    (bus.cond),
    .op_i      (bus.op),
    .funct_i   (bus.funct),
    .rn_i      (bus.rn),
    .rd_i      (bus.rd),
    .operand_i (bus.operand),
    .word_o    (pk_word),
    .illegal_o (pk_illegal)
  );

  // Ready is a pure decode of registered state, so it never depends on in_valid.
  assign in_ready = ((state_q == LOAD) || (state_q == FULL)) && !last_q;
  assign accept   = bus.in_valid && in_ready;

  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    addr_d      = addr_q;
    we_d        = 1'b0;
    waddr_d     = waddr_q;
    wdata_d     = wdata_q;
    core_hold_d = core_hold_q;
    done_d      = 1'b0;
    err_d       = err_q;
    count_d     = count_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d     = LOAD;
          last_d      = 1'b0;
          addr_d      = BaseAddr;
          core_hold_d = 1'b1;
          err_d       = 1'b0;
          count_d     = '0;
        end
      end

      LOAD: begin
        if (last_q) begin
          // The final word was written last cycle; close the session now.
          state_d = DONE;
          last_d  = 1'b0;
          done_d  = 1'b1;
        end else if (accept) begin
          if (pk_illegal) begin
            // Nothing to write, but the session still ends on in_last.
            err_d = 1'b1;
            if (bus.in_last) begin
              state_d = DONE;
              done_d  = 1'b1;
            end
          end else begin
            we_d    = 1'b1;
            waddr_d = addr_q;
            wdata_d = pk_word;
            addr_d  = addr_q + AddrOne;
            count_d = count_q + CountOne;
            if (bus.in_last) begin
              last_d = 1'b1;
            end else if (addr_q == LastAddr) begin
              // Memory is full; never wrap onto earlier words.
              state_d = FULL;
            end
          end
        end
      end

      FULL: begin
        // Every bundle here is discarded; only in_last ends the session.
        if (accept) begin
          err_d = 1'b1;
          if (bus.in_last) begin
            state_d = DONE;
            done_d  = 1'b1;
          end
        end
      end

      DONE: begin
        state_d     = IDLE;
        core_hold_d = 1'b0;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      last_q      <= 1'b0;
      addr_q      <= BaseAddr;
      we_q        <= 1'b0;
      waddr_q     <= '0;
      wdata_q     <= '0;
      core_hold_q <= 1'b1;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      addr_q      <= addr_d;
      we_q        <= we_d;
      waddr_q     <= waddr_d;
      wdata_q     <= wdata_d;
      core_hold_q <= core_hold_d;
      done_q      <= done_d;
      err_q       <= err_d;
      count_q     <= count_d;
    end
  end

  assign bus.in_ready   = in_ready;
  assign bus.imem_we    = we_q;
  assign bus.imem_addr  = waddr_q;
  assign bus.imem_wdata = wdata_q;

  assign core_hold  = core_hold_q;
  assign busy       = (state_q != IDLE);
  assign done       = done_q;
  assign err        = err_q;
  assign word_count = count_q;

endmodule
